// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int OPCODE_LSB = 0;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT7B5_BIT = 30;
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
    typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetched words with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign push_ok = push && (!full || pop);
    assign pop_ok = pop && !empty;
    assign head = mem[rd_ptr];
    // flush discards everything; a push arriving with a flush is wrong-path and dropped too
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited imem fetcher with instruction buffer and redirect flush
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2,
    parameter int              MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    fetch_state_t state;
    logic [XLEN-1:0] fetch_pc, rsp_pc, target;
    logic [OW-1:0] outstanding, drop_cnt, out_next;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic full, empty, req_fire, pop, redir, drop, push;
    fetch_entry_t head;
    // credit: never let buffered plus in-flight words exceed the buffer
    assign imem_req_valid = reset_n && state == RUN && !full && int'(outstanding) < MAX_OUTST
                            && int'(count) + int'(outstanding) < FIFO_DEPTH;
    assign imem_req_addr = fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign instr_valid = !empty && state == RUN;
    assign pop = instr_valid && instr_ready;
    assign redir = pop && redirect_valid;
    assign drop = imem_rsp_valid && drop_cnt != '0;
    assign push = imem_rsp_valid && drop_cnt == '0;
    assign out_next = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
    assign target = redirect_target & ~32'd3;
    assign instr = instr_valid ? head.instr : '0;
    assign instr_pc = instr_valid ? head.pc : '0;
    assign instr_pc_plus4 = instr_valid ? head.pc + 32'd4 : '0;
    assign op = instr[OPCODE_LSB +: 7];
    assign funct3 = instr[FUNCT3_LSB +: 3];
    assign funct7b5 = instr[FUNCT7B5_BIT];
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ('{instr: imem_rsp_data, pc: rsp_pc}),
        .pop       (pop),
        .flush     (redir),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );
    // fetch/response PCs, in-flight count and flush bookkeeping; a redirect turns every in-flight request into a drop
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_next;
            if (redir) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                drop_cnt <= out_next;
                state    <= out_next != '0 ? FLUSH : RUN;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (push) rsp_pc <= rsp_pc + 32'd4;
                if (drop) drop_cnt <= drop_cnt - OW'(1);
                if (drop && drop_cnt == OW'(1)) state <= RUN;
            end
        end
    end
endmodule
